// File: rtl/sync_token_sink.sv
// Synchronous sink for a 4-phase bundled-data channel: resynchronises the request,
// buffers {data, timing-error flag} tokens in a FIFO, and counts error-flagged tokens.
module sync_token_sink #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    output logic              ack_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        err_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_C  = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    // Dual-rail decode: only 01 means "no timing error"; illegal codes are treated as errors.
    function automatic logic flag_of(input logic [1:0] e);
        case (e)
            2'b01:   flag_of = 1'b0;
            2'b10:   flag_of = 1'b1;
            default: flag_of = 1'b1;
        endcase
    endfunction

    function automatic logic illegal_of(input logic [1:0] e);
        case (e)
            2'b00:   illegal_of = 1'b1;
            2'b11:   illegal_of = 1'b1;
            default: illegal_of = 1'b0;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    state_t                 state_r, state_nxt_s;
    logic                   push_s, pop_s, inc_s;
    logic [DATA_W:0]        mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r, rd_ptr_r, rd_nxt_s;
    logic [AW:0]            count_r, count_nxt_s;
    logic [DATA_W:0]        wdata_s, head_nxt_s;

    assign req_s   = sync_r[SYNC_STAGES-1];
    assign pop_s   = out_valid & out_ready;
    assign wdata_s = {data_in, flag_of(err_in)};
    assign inc_s   = push_s & wdata_s[0];

    // Request synchroniser chain; nothing downstream looks at req_in directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], req_in};
        end
    end

    // Handshake next-state: capture only when the registered occupancy leaves room.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && (count_r != FULL_C)) begin
                    push_s      = 1'b1;
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACK;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FIFO bookkeeping and the next head word, so the output stage can be a plain register.
    always_comb begin
        count_nxt_s = count_r;
        rd_nxt_s    = rd_ptr_r;
        head_nxt_s  = '0;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + (AW+1)'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - (AW+1)'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
        // The new head is the word being written when the FIFO is (or is about to be) empty.
        if (count_nxt_s == '0) begin
            head_nxt_s = '0;
        end else if (push_s && (rd_nxt_s == wr_ptr_r)) begin
            head_nxt_s = wdata_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Control state, pointers and the registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ack_out   <= 1'b0;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ack_out   <= (state_nxt_s == ACK);
            rd_ptr_r  <= rd_nxt_s;
            count_r   <= count_nxt_s;
            out_valid <= (count_nxt_s != '0);
            {out_data, out_err} <= head_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    // Saturating error-token counter; a clear coinciding with a capture still counts that token.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= inc_s ? CNT_W'(1) : '0;
        end else if (inc_s && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end else begin
            err_cnt <= err_cnt;
        end
    end

    // Sticky protocol-violation flag for illegal dual-rail codes at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (push_s && illegal_of(err_in)) begin
            proto_err <= 1'b1;
        end else begin
            proto_err <= proto_err;
        end
    end

endmodule

// File: tb/tb_sync_token_sink.sv
// Scoreboard bench for sync_token_sink: a token-level model predicts the output stream and
// counters; a negedge monitor checks every accepted head word against the expected queue.
module tb_sync_token_sink;

    logic        clk = 1'b0;
    logic        rst, req_in, out_ready, cnt_clr;
    logic [7:0]  data_in;
    logic [1:0]  err_in;
    logic        ack_out, out_valid, out_err, proto_err;
    logic [7:0]  out_data;
    logic [15:0] err_cnt;
    logic        ack2, ov2, oe2, pe2;
    logic [7:0]  od2;
    logic [1:0]  ec2;

    int          n_vec = 0;
    int          n_miss = 0;
    int          rmode = 0;
    int          m_cnt, m_cnt2;
    bit          m_proto;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_e, hold_d;
    bit          hold_v;

    always #5 clk = ~clk;

    sync_token_sink #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack_out),
        .data_in(data_in), .err_in(err_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .cnt_clr(cnt_clr), .err_cnt(err_cnt), .proto_err(proto_err)
    );

    // Narrow-counter instance on the same inputs, used for saturation.
    sync_token_sink #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack2),
        .data_in(data_in), .err_in(err_in), .out_valid(ov2),
        .out_ready(out_ready), .out_data(od2), .out_err(oe2),
        .cnt_clr(cnt_clr), .err_cnt(ec2), .proto_err(pe2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Token-level model: what a captured token contributes to stream and counters.
    task automatic note_capture(input logic [7:0] d, input logic [1:0] e);
        bit f;
        f = (e != 2'b01);
        exp_q.push_back({d, f});
        if (f) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : 65535;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
        end
        if (e == 2'b00 || e == 2'b11) m_proto = 1'b1;
    endtask

    task automatic wait_ack(input logic lvl, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ack_out === lvl) break;
        end
        check(nm, ack_out, lvl);
    endtask

    task automatic send_token(input logic [7:0] d, input logic [1:0] e);
        note_capture(d, e);
        data_in = d;
        err_in  = e;
        req_in  = 1'b1;
        wait_ack(1'b1, 200, "ack rise");
        req_in  = 1'b0;
        wait_ack(1'b0, 50, "ack fall");
    endtask

    task automatic check_counts(input string nm);
        check({nm, " err_cnt"}, err_cnt, m_cnt);
        check({nm, " err_cnt2"}, ec2, m_cnt2);
        check({nm, " proto_err"}, proto_err, m_proto);
    endtask

    task automatic drain();
        rmode = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain queue", exp_q.size(), 0);
        check("drain valid", out_valid, 1'b0);
    endtask

    // Consumer-side ready pattern, updated away from the edge the main thread uses.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the expected queue on every accepted head, and checks stalled heads hold.
    initial begin
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) check("head hold", {out_data, out_err}, hold_d);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected pop: got %0h, expected none", {out_data, out_err});
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("head token", {out_data, out_err}, mon_e);
                    end
                    hold_v = 1'b0;
                end else if (out_valid) begin
                    hold_v = 1'b1;
                    hold_d = {out_data, out_err};
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [1:0] e;
        int r;
        rst = 1'b1; req_in = 1'b0; data_in = 8'h00; err_in = 2'b01; cnt_clr = 1'b0;
        m_cnt = 0; m_cnt2 = 0; m_proto = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset ack", ack_out, 1'b0);
        check("reset valid", out_valid, 1'b0);
        check("reset data", {out_data, out_err}, 9'h000);
        check_counts("reset");

        // Single token with exact handshake latency.
        rmode = 1;
        note_capture(8'hA5, 2'b01);
        data_in = 8'hA5; err_in = 2'b01; req_in = 1'b1;
        tick();
        tick();
        check("latency edge2 ack", ack_out, 1'b0);
        tick();
        check("latency edge3 ack", ack_out, 1'b1);
        req_in = 1'b0;
        tick();
        tick();
        check("fall edge2 ack", ack_out, 1'b1);
        tick();
        check("fall edge3 ack", ack_out, 1'b0);
        check_counts("single");

        // Error-flagged and illegal tokens.
        send_token(8'h3C, 2'b10);
        check_counts("err10");
        send_token(8'h5A, 2'b11);
        check_counts("err11");
        drain();

        // Backpressure: four tokens fill the FIFO, the fifth waits for a slot.
        rmode = 0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) send_token(8'hA0 + 8'(i), 2'b01);
        note_capture(8'hA4, 2'b01);
        data_in = 8'hA4; err_in = 2'b01; req_in = 1'b1;
        repeat (10) tick();
        check("full ack held", ack_out, 1'b0);
        check("full valid", out_valid, 1'b1);
        rmode = 1;
        tick();
        rmode = 0;
        wait_ack(1'b1, 20, "bp ack rise");
        req_in = 1'b0;
        wait_ack(1'b0, 20, "bp ack fall");
        drain();

        // Counter clear alone, saturation, then clear coinciding with a capture.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        m_cnt = 0; m_cnt2 = 0;
        check_counts("clr alone");
        for (int i = 0; i < 5; i++) send_token(8'($urandom), 2'b10);
        check_counts("saturate");
        drain();
        exp_q.push_back({8'hC3, 1'b1});
        data_in = 8'hC3; err_in = 2'b10; req_in = 1'b1;
        tick();
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        m_cnt = 1; m_cnt2 = 1;
        check("clr+inc ack", ack_out, 1'b1);
        req_in = 1'b0;
        wait_ack(1'b0, 20, "clr ack fall");
        check_counts("clr+inc");

        // Randomised traffic with random consumer stalls (push/pop overlap and pointer wrap).
        rmode = 2;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      e = 2'b01;
            else if (r < 8) e = 2'b10;
            else if (r == 8) e = 2'b00;
            else            e = 2'b11;
            d = 8'($urandom);
            send_token(d, e);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        check_counts("random");

        // Reset mid-handshake with req_in still high: state cleared, token recaptured once.
        rmode = 0;
        tick();
        tick();
        note_capture(8'h77, 2'b01);
        data_in = 8'h77; err_in = 2'b01; req_in = 1'b1;
        wait_ack(1'b1, 20, "pre-reset ack");
        check("pre-reset valid", out_valid, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        m_cnt = 0; m_cnt2 = 0; m_proto = 1'b0;
        tick();
        check("mid reset ack", ack_out, 1'b0);
        check("mid reset valid", out_valid, 1'b0);
        check_counts("mid reset");
        rst = 1'b0;
        note_capture(8'h77, 2'b01);
        wait_ack(1'b1, 20, "recapture ack");
        req_in = 1'b0;
        wait_ack(1'b0, 20, "recapture fall");
        drain();
        repeat (5) tick();
        check("recapture once valid", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
